pkt_que_wr: RTL and testbench

Packet ingress queue writer for the pkt_iQue path. It consumes the word stream leaving the input delay pipeline (valid/sop/eop/data, no backpressure) and reserves space for a maximum-size packet at each SOP. Admitted packets are written into an on-chip FIFO, and packets that cannot be guaranteed space are dropped whole. Oversize packets are truncated with a forced EOP. Queued words are presented cut-through on a valid/ready interface toward the downstream parser.

---
 rtl/pkt_ique_pkg.sv | 18 +
 rtl/pkt_que_wr_if.sv | 25 ++
 rtl/pkt_que_ram.sv | 24 ++
 rtl/pkt_que_wr.sv | 177 +++++++++++++++++
 tb/tb_pkt_que_wr.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_ique_pkg.sv
// Shared definitions for the pkt_iQue ingress path: write-FSM encoding and
// storage-entry field positions.
package pkt_ique_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  // Entry layout is {sop, eop, data}.
  function automatic int sop_pos(input int dwid);
    return dwid + 1;
  endfunction

  function automatic int eop_pos(input int dwid);
    return dwid;
  endfunction

endpackage

// File: rtl/pkt_que_wr_if.sv
// Word stream into the queue writer and valid/ready stream out to the parser.
interface pkt_que_wr_if #(
  parameter int DWID = 64
);
  logic            in_vld;
  logic            in_sop;
  logic            in_eop;
  logic [DWID-1:0] in_data;
  logic            out_vld;
  logic            out_rdy;
  logic            out_sop;
  logic            out_eop;
  logic [DWID-1:0] out_data;

  modport master (
    output in_vld, in_sop, in_eop, in_data, out_rdy,
    input  out_vld, out_sop, out_eop, out_data
  );

  modport slave (
    input  in_vld, in_sop, in_eop, in_data, out_rdy,
    output out_vld, out_sop, out_eop, out_data
  );

endinterface

// File: rtl/pkt_que_ram.sv
// Simple dual-port storage for queue entries: registered write, asynchronous read.
module pkt_que_ram #(
  parameter int WID  = 66,
  parameter int AWID = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AWID-1:0] waddr,
  input  logic [WID-1:0]  wdata,
  input  logic [AWID-1:0] raddr,
  output logic [WID-1:0]  rdata
);

  logic [WID-1:0] mem [1 << AWID];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_que_wr.sv
// Ingress queue writer: reserves room for a max-size packet at each SOP, drops
// packets that cannot be guaranteed space, truncates oversize ones, cut-through out.
module pkt_que_wr
  import pkt_ique_pkg::*;
#(
  parameter int DWID          = 64,
  parameter int AWID          = 9,
  parameter int MAX_PKT_WORDS = 190
) (
  input  logic           clk,
  input  logic           rst,
  pkt_que_wr_if.slave    bus,
  output logic [AWID:0]  fifo_cnt,
  output logic [31:0]    pkt_cnt,
  output logic [31:0]    drop_cnt,
  output logic [15:0]    err_cnt
);

  localparam int EWID    = DWID + 2;
  localparam int DEPTH   = 1 << AWID;
  localparam int SOP_POS = sop_pos(DWID);
  localparam int EOP_POS = eop_pos(DWID);
  localparam logic [AWID+1:0] DEPTH_W = (AWID+2)'(DEPTH);
  localparam logic [AWID+1:0] MAX_W   = (AWID+2)'(MAX_PKT_WORDS);
  localparam logic [AWID:0]   MAX_C   = (AWID+1)'(MAX_PKT_WORDS);
  localparam logic [AWID:0]   ONE_C   = (AWID+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [AWID:0]   wcnt_q, wcnt_d;
  logic [AWID:0]   wptr_q, wptr_d;
  logic [AWID:0]   rptr_q, rptr_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [31:0]     drop_cnt_q, drop_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            out_vld_q, out_vld_d;
  logic [EWID-1:0] out_ent_q, out_ent_d;

  logic            wr_req, wr_en, wr_eop;
  logic            pkt_inc, drop_inc;
  logic            err_proto, err_trunc, err_full;
  logic [1:0]      err_add;
  logic [16:0]     err_sum;
  logic            full, empty, pop, admit_ok;
  logic [AWID+1:0] free;
  logic [EWID-1:0] wr_ent, rd_ent;

  assign fifo_cnt = wptr_q - rptr_q;
  assign free     = DEPTH_W - {1'b0, fifo_cnt};
  assign admit_ok = (free >= MAX_W);
  assign full     = (wptr_q[AWID] != rptr_q[AWID]) && (wptr_q[AWID-1:0] == rptr_q[AWID-1:0]);
  assign empty    = (wptr_q == rptr_q);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_req    = 1'b0;
    wr_eop    = bus.in_eop;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    err_proto = 1'b0;
    err_trunc = 1'b0;
    if (bus.in_vld) begin
      if (bus.in_sop) begin
        // A SOP always restarts admission; outside IDLE it also marks a broken packet.
        err_proto = (state_q != ST_IDLE);
        if (admit_ok) begin
          wr_req = 1'b1;
          wcnt_d = ONE_C;
          if (bus.in_eop) begin
            pkt_inc = 1'b1;
            state_d = ST_IDLE;
          end else if (MAX_C == ONE_C) begin
            wr_eop    = 1'b1;
            pkt_inc   = 1'b1;
            err_trunc = 1'b1;
            state_d   = ST_DROP;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          drop_inc = 1'b1;
          state_d  = bus.in_eop ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_WRITE: begin
            wr_req = 1'b1;
            wcnt_d = wcnt_q + ONE_C;
            if (bus.in_eop) begin
              pkt_inc = 1'b1;
              state_d = ST_IDLE;
            end else if (wcnt_d == MAX_C) begin
              wr_eop    = 1'b1;
              pkt_inc   = 1'b1;
              err_trunc = 1'b1;
              state_d   = ST_DROP;
            end
          end
          ST_DROP: begin
            if (bus.in_eop) begin
              state_d = ST_IDLE;
            end
          end
          ST_IDLE: err_proto = 1'b1;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    wr_ent          = '0;
    wr_ent[DWID-1:0] = bus.in_data;
    wr_ent[EOP_POS] = wr_eop;
    wr_ent[SOP_POS] = bus.in_sop;
  end

  // The reservation makes a full-FIFO write unreachable; guard it anyway.
  assign wr_en    = wr_req & ~full;
  assign err_full = wr_req & full;
  assign pop      = ~empty & (~out_vld_q | bus.out_rdy);

  assign wptr_d     = wptr_q + (AWID+1)'(wr_en);
  assign rptr_d     = rptr_q + (AWID+1)'(pop);
  assign out_vld_d  = pop | (out_vld_q & ~bus.out_rdy);
  assign out_ent_d  = pop ? rd_ent : out_ent_q;
  assign pkt_cnt_d  = pkt_cnt_q + 32'(pkt_inc);
  assign drop_cnt_d = drop_cnt_q + 32'(drop_inc);
  assign err_add    = 2'(err_proto) + 2'(err_trunc) + 2'(err_full);
  assign err_sum    = {1'b0, err_cnt_q} + 17'(err_add);
  assign err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  pkt_que_ram #(
    .WID  (EWID),
    .AWID (AWID)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[AWID-1:0]),
    .wdata (wr_ent),
    .raddr (rptr_q[AWID-1:0]),
    .rdata (rd_ent)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_ent_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
      out_vld_q  <= out_vld_d;
      out_ent_q  <= out_ent_d;
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.out_sop  = out_ent_q[SOP_POS];
  assign bus.out_eop  = out_ent_q[EOP_POS];
  assign bus.out_data = out_ent_q[DWID-1:0];
  assign pkt_cnt      = pkt_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pkt_que_wr.sv
// Bench for pkt_que_wr: packet-level reference model predicts admission, counters
// and occupancy; a monitor compares every output transfer against the expected queue.
module tb_pkt_que_wr;

  localparam int DWID  = 64;
  localparam int AWID  = 9;
  localparam int MAXW  = 190;
  localparam int DEPTH = 1 << AWID;
  localparam int S_IDLE  = 0;
  localparam int S_WRITE = 1;
  localparam int S_DROP  = 2;
  localparam int N_RAND  = 300;

  logic          clk;
  logic          rst;
  logic [AWID:0] fifo_cnt;
  logic [31:0]   pkt_cnt;
  logic [31:0]   drop_cnt;
  logic [15:0]   err_cnt;

  pkt_que_wr_if #(.DWID(DWID)) bus ();

  pkt_que_wr #(
    .DWID          (DWID),
    .AWID          (AWID),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .fifo_cnt (fifo_cnt),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: packet-level FSM, words held inside the block,
  // and whether the output register is occupied.
  int          m_st;
  int          m_wcnt;
  int          m_occ;
  int          m_ofull;
  int unsigned e_pkt;
  int unsigned e_drop;
  int unsigned e_err;
  int          rdy_mode;
  logic [DWID+1:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DWID-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic bump_err();
    if (e_err < 32'hFFFF) e_err++;
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_wcnt = 0; m_occ = 0; m_ofull = 0;
    e_pkt = 0; e_drop = 0; e_err = 0;
    sb_q.delete();
  endtask

  // Applies one clock edge of the specification's rules to the model.
  task automatic model_edge(input bit v, input bit s, input bit e, input logic [DWID-1:0] d);
    int free;
    int fifo_pre;
    int xfer;
    bit wr;
    bit weop;
    free = DEPTH - (m_occ - m_ofull);
    wr   = 1'b0;
    weop = e;
    if (v) begin
      if (s) begin
        if (m_st != S_IDLE) bump_err();
        if (free >= MAXW) begin
          wr = 1'b1; m_wcnt = 1;
          if (e) e_pkt++;
          m_st = e ? S_IDLE : S_WRITE;
        end else begin
          e_drop++;
          m_st = e ? S_IDLE : S_DROP;
        end
      end else if (m_st == S_IDLE) begin
        bump_err();
      end else if (m_st == S_WRITE) begin
        wr = 1'b1; m_wcnt++;
        if (e) begin
          e_pkt++; m_st = S_IDLE;
        end else if (m_wcnt == MAXW) begin
          weop = 1'b1; e_pkt++; bump_err(); m_st = S_DROP;
        end
      end else if (e) begin
        m_st = S_IDLE;
      end
    end
    if (wr) sb_q.push_back({s, weop, d});
    fifo_pre = m_occ - m_ofull;
    xfer     = (m_ofull == 1 && bus.out_rdy) ? 1 : 0;
    m_ofull  = ((m_ofull == 1 && !bus.out_rdy) || fifo_pre > 0) ? 1 : 0;
    m_occ    = m_occ - xfer + (wr ? 1 : 0);
  endtask

  // One clock: check the state left by the previous edge, then drive the next word.
  task automatic step(input bit v, input bit s, input bit e, input logic [DWID-1:0] d);
    @(negedge clk);
    chk("out_vld",  66'(bus.out_vld), 66'(m_ofull));
    chk("fifo_cnt", 66'(fifo_cnt),    66'(m_occ - m_ofull));
    chk("pkt_cnt",  66'(pkt_cnt),     66'(e_pkt));
    chk("drop_cnt", 66'(drop_cnt),    66'(e_drop));
    chk("err_cnt",  66'(err_cnt),     66'(e_err));
    case (rdy_mode)
      0:       bus.out_rdy = 1'b0;
      1:       bus.out_rdy = 1'b1;
      default: bus.out_rdy = 1'($urandom_range(0, 1));
    endcase
    bus.in_vld  = v;
    bus.in_sop  = s;
    bus.in_eop  = e;
    bus.in_data = d;
    model_edge(v, s, e, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_pkt(input int len, input bit with_eop);
    for (int i = 0; i < len; i++) step(1'b1, i == 0, with_eop && (i == len - 1), rand64());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_data = '0;
    bus.out_rdy = 1'b0;
    model_reset();
    #1;
    chk("rst_out_vld",  66'(bus.out_vld),  66'(0));
    chk("rst_out_sop",  66'(bus.out_sop),  66'(0));
    chk("rst_out_eop",  66'(bus.out_eop),  66'(0));
    chk("rst_out_data", 66'(bus.out_data), 66'(0));
    chk("rst_fifo_cnt", 66'(fifo_cnt),     66'(0));
    chk("rst_counters", 66'({pkt_cnt, drop_cnt} | 64'(err_cnt)), 66'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 2000 && m_occ > 0; i++) idle(1);
    idle(2);
    chk("drain_fifo_cnt", 66'(fifo_cnt),     66'(0));
    chk("drain_out_vld",  66'(bus.out_vld),  66'(0));
    chk("drain_sb_left",  66'(sb_q.size()),  66'(0));
  endtask

  // Scoreboard monitor: every accepted output word must be the next expected entry.
  initial begin
    logic [DWID+1:0] exp_w;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.out_vld && bus.out_rdy) begin
        if (sb_q.size() == 0) begin
          chk("out_unexpected", 66'({bus.out_sop, bus.out_eop, bus.out_data}), 66'(0));
        end else begin
          exp_w = sb_q.pop_front();
          chk("out_word", 66'({bus.out_sop, bus.out_eop, bus.out_data}), 66'(exp_w));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_data = '0;
    bus.out_rdy = 1'b0;
    rdy_mode = 1;
    model_reset();

    // Short packet, cut-through with ready held high.
    do_reset();
    rdy_mode = 1;
    send_pkt(3, 1'b1);
    idle(6);
    chk("t1_pkt_cnt",  66'(pkt_cnt),  66'(1));
    chk("t1_fifo_cnt", 66'(fifo_cnt), 66'(0));

    // Two maximum packets fill the reservation; the third cannot be guaranteed.
    do_reset();
    rdy_mode = 0;
    send_pkt(MAXW, 1'b1);
    send_pkt(MAXW, 1'b1);
    idle(1);
    chk("t2_fifo_after_2", 66'(fifo_cnt), 66'(379));
    send_pkt(MAXW, 1'b1);
    idle(1);
    chk("t2_drop_cnt",     66'(drop_cnt), 66'(1));
    chk("t2_fifo_after_3", 66'(fifo_cnt), 66'(379));
    chk("t2_pkt_cnt",      66'(pkt_cnt),  66'(2));
    drain();

    // Oversize packet is truncated with a forced EOP.
    do_reset();
    rdy_mode = 1;
    send_pkt(200, 1'b1);
    idle(4);
    chk("t3_err_cnt", 66'(err_cnt), 66'(1));
    chk("t3_pkt_cnt", 66'(pkt_cnt), 66'(1));
    drain();

    // Single-word packet, then a packet missing EOP, then a fresh SOP.
    do_reset();
    rdy_mode = 1;
    send_pkt(1, 1'b1);
    send_pkt(3, 1'b0);
    step(1'b1, 1'b1, 1'b0, rand64());
    idle(1);
    chk("t4_pkt_cnt", 66'(pkt_cnt), 66'(1));
    chk("t4_err_cnt", 66'(err_cnt), 66'(1));
    step(1'b1, 1'b0, 1'b1, rand64());
    idle(1);
    chk("t4_pkt_cnt_end", 66'(pkt_cnt), 66'(2));
    drain();

    // Reset in the middle of a stalled packet.
    do_reset();
    rdy_mode = 0;
    send_pkt(41, 1'b0);
    idle(1);
    chk("t5_fifo_pre", 66'(fifo_cnt),    66'(40));
    chk("t5_vld_pre",  66'(bus.out_vld), 66'(1));
    do_reset();
    rdy_mode = 1;
    step(1'b1, 1'b0, 1'b0, rand64());
    step(1'b1, 1'b0, 1'b1, rand64());
    send_pkt(5, 1'b1);
    idle(8);
    chk("t5_err_cnt", 66'(err_cnt), 66'(2));
    chk("t5_pkt_cnt", 66'(pkt_cnt), 66'(1));
    drain();

    // Random lengths at full input load against a randomly stalling sink.
    do_reset();
    rdy_mode = 2;
    for (int p = 0; p < N_RAND; p++) send_pkt($urandom_range(1, MAXW), 1'b1);
    drain();
    chk("rand_pkt_plus_drop", 66'(pkt_cnt + drop_cnt), 66'(N_RAND));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
